// File: rtl/fwrisc_mds_pkg.sv
// rtl/fwrisc_mds_pkg.sv - shared op codes, decode constants and issue FSM states
// for the mul/div/shift issue path.
package fwrisc_mds_pkg;

  typedef enum logic [3:0] {
    OP_SLL   = 4'd0,
    OP_SRL   = 4'd1,
    OP_SRA   = 4'd2,
    OP_MUL   = 4'd3,
    OP_MULH  = 4'd4,
    OP_MULS  = 4'd5,
    OP_MULSH = 4'd6,
    OP_DIV   = 4'd7,
    OP_REM   = 4'd8
  } mds_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } mds_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

endpackage

// File: rtl/fwrisc_mds_decode.sv
// rtl/fwrisc_mds_decode.sv - combinational decode of an instruction word into
// an mds unit op, a legality flag and an immediate-operand select.
module fwrisc_mds_decode
  import fwrisc_mds_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  op,
  output logic        legal,
  output logic        use_imm
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    op      = OP_SLL;
    legal   = 1'b0;
    use_imm = 1'b0;
    if (opcode == OPC_OP) begin
      case (funct7)
        F7_BASE: begin
          if (funct3 == 3'b001) begin
            op    = OP_SLL;
            legal = 1'b1;
          end else if (funct3 == 3'b101) begin
            op    = OP_SRL;
            legal = 1'b1;
          end
        end
        F7_ALT: begin
          if (funct3 == 3'b101) begin
            op    = OP_SRA;
            legal = 1'b1;
          end
        end
        F7_MULDIV: begin
          // MULHSU, DIVU and REMU are not supported by the unit
          case (funct3)
            3'b000:  begin op = OP_MUL;   legal = 1'b1; end
            3'b001:  begin op = OP_MULSH; legal = 1'b1; end
            3'b011:  begin op = OP_MULH;  legal = 1'b1; end
            3'b100:  begin op = OP_DIV;   legal = 1'b1; end
            3'b110:  begin op = OP_REM;   legal = 1'b1; end
            default: legal = 1'b0;
          endcase
        end
        default: legal = 1'b0;
      endcase
    end else if (opcode == OPC_OP_IMM) begin
      use_imm = 1'b1;
      if (funct3 == 3'b001 && funct7 == F7_BASE) begin
        op    = OP_SLL;
        legal = 1'b1;
      end else if (funct3 == 3'b101 && funct7 == F7_BASE) begin
        op    = OP_SRL;
        legal = 1'b1;
      end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
        op    = OP_SRA;
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwrisc_mds_issue.sv
// rtl/fwrisc_mds_issue.sv - issues one instruction at a time to the multi-cycle
// mul/div/shift unit and hands the result (or an error) to writeback.
module fwrisc_mds_issue
  import fwrisc_mds_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic [31:0] mds_a,
  output logic [31:0] mds_b,
  output logic [3:0]  mds_op,
  output logic        mds_valid,
  input  logic [31:0] mds_out,
  input  logic        mds_out_valid,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mds_state_t    state;
  mds_state_t    state_n;
  logic [CW-1:0] wait_count;
  logic [3:0]    dec_op;
  logic          dec_legal;
  logic          dec_imm;
  logic          accept;
  logic          bypass;
  logic          timed_out;

  fwrisc_mds_decode u_decode (
    .instr   (req_instr),
    .op      (dec_op),
    .legal   (dec_legal),
    .use_imm (dec_imm)
  );

  assign req_ready = (state == IDLE) && !reset;
  assign mds_valid = (state == ISSUE);
  assign wb_valid  = (state == WB);
  assign accept    = req_valid && req_ready;
  // divide/remainder by zero has an architecturally fixed answer, so skip the unit
  assign bypass    = dec_legal && (dec_op == OP_DIV || dec_op == OP_REM) && (req_rs2 == 32'd0);
  assign timed_out = (wait_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = (!dec_legal || bypass) ? WB : ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (mds_out_valid || timed_out) begin
          state_n = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mds_a      <= 32'd0;
      mds_b      <= 32'd0;
      mds_op     <= 4'd0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      wb_err     <= 1'b0;
      wait_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mds_a      <= req_rs1;
            mds_b      <= dec_imm ? {27'd0, req_instr[24:20]} : req_rs2;
            mds_op     <= dec_op;
            wb_rd      <= req_rd;
            wait_count <= '0;
            if (!dec_legal) begin
              wb_err  <= 1'b1;
              wb_data <= 32'd0;
            end else if (bypass) begin
              wb_err  <= 1'b0;
              wb_data <= (dec_op == OP_DIV) ? 32'hFFFF_FFFF : req_rs1;
            end else begin
              wb_err  <= 1'b0;
              wb_data <= 32'd0;
            end
          end
        end
        WAIT: begin
          if (mds_out_valid) begin
            wb_data <= mds_out;
            wb_err  <= 1'b0;
          end else if (timed_out) begin
            wb_data <= 32'd0;
            wb_err  <= 1'b1;
          end else begin
            wait_count <= wait_count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_mds_issue.sv
// tb/tb_fwrisc_mds_issue.sv - directed vector table, random ops against a
// reference model, plus timeout, backpressure and reset-in-WAIT sequences.
module tb_fwrisc_mds_issue;

  localparam int TO = 40;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic [31:0] mds_a;
  logic [31:0] mds_b;
  logic [3:0]  mds_op;
  logic        mds_valid;
  logic [31:0] mds_out;
  logic        mds_out_valid;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int tests = 0;
  int fails = 0;

  // behavioural unit controls
  int          unit_lat = 0;
  bit          unit_silent = 0;
  bit          unit_enable = 1;
  logic        inject_valid = 0;
  logic [31:0] inject_data = 0;

  fwrisc_mds_issue #(.TIMEOUT(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_instr     (req_instr),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_rd        (req_rd),
    .mds_a         (mds_a),
    .mds_b         (mds_b),
    .mds_op        (mds_op),
    .mds_valid     (mds_valid),
    .mds_out       (mds_out),
    .mds_out_valid (mds_out_valid),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_err        (wb_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          lat;
    bit          silent;
    int          bp;
    bit          unit;
    logic [3:0]  op;
    logic [31:0] b;
    logic [31:0] data;
    bit          err;
    int          n;
  } vec_t;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc, input logic [4:0] sh);
    return {f7, sh, 5'd1, f3, 5'd2, opc};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [4:0] rd, input int lat,
                              input bit silent, input int bp, input bit unit, input logic [3:0] op,
                              input logic [31:0] b, input logic [31:0] data, input bit err, input int n);
    vec_t v;
    v.name = name; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.lat = lat;
    v.silent = silent; v.bp = bp; v.unit = unit; v.op = op; v.b = b; v.data = data;
    v.err = err; v.n = n;
    return v;
  endfunction

  // arithmetic the unit model performs; ops numbered as the package defines them
  function automatic logic [31:0] unit_compute(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return a << b[4:0];
      4'd1: return a >> b[4:0];
      4'd2: return $signed(a) >>> b[4:0];
      4'd3: return a * b;
      4'd4, 4'd5, 4'd6: begin p = sa * sb; return p[63:32]; end
      4'd7: begin if (sb == 0) return 32'd0; p = sa / sb; return p[31:0]; end
      4'd8: begin if (sb == 0) return 32'd0; p = sa % sb; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] mnem_op(input string m);
    case (m)
      "SLL":   return 4'd0;
      "SRL":   return 4'd1;
      "SRA":   return 4'd2;
      "MUL":   return 4'd3;
      "MULH":  return 4'd4;
      "MULSH": return 4'd6;
      "DIV":   return 4'd7;
      "REM":   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic void ref_model(input logic [31:0] instr, input logic [31:0] rs1,
                                    input logic [31:0] rs2, output bit unit, output logic [3:0] op,
                                    output logic [31:0] b, output logic [31:0] data, output bit err);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    string      m;
    bit         imm;
    opc = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
    m = ""; imm = (opc == 7'h13);
    if (opc == 7'h33 && f7 == 7'h00) m = (f3 == 3'd1) ? "SLL" : (f3 == 3'd5) ? "SRL" : "";
    else if (opc == 7'h33 && f7 == 7'h20) m = (f3 == 3'd5) ? "SRA" : "";
    else if (opc == 7'h33 && f7 == 7'h01) begin
      case (f3)
        3'd0: m = "MUL";
        3'd1: m = "MULSH";
        3'd3: m = "MULH";
        3'd4: m = "DIV";
        3'd6: m = "REM";
        default: m = "";
      endcase
    end
    else if (imm && f3 == 3'd1 && f7 == 7'h00) m = "SLL";
    else if (imm && f3 == 3'd5 && f7 == 7'h00) m = "SRL";
    else if (imm && f3 == 3'd5 && f7 == 7'h20) m = "SRA";
    op = mnem_op(m);
    b = imm ? {27'd0, instr[24:20]} : rs2;
    unit = 0; err = 0; data = 32'd0;
    if (m == "") err = 1;
    else if (m == "DIV" && rs2 == 32'd0) data = 32'hFFFF_FFFF;
    else if (m == "REM" && rs2 == 32'd0) data = rs1;
    else begin unit = 1; data = unit_compute(op, rs1, b); end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mds unit: result appears lat cycles into WAIT, one-cycle pulse
  initial begin
    bit          pending;
    int          cnt;
    logic [31:0] res;
    pending = 0; cnt = 0; res = 0;
    mds_out_valid = 1'b0;
    mds_out = 32'd0;
    forever begin
      @(posedge clock); #2;
      if (unit_enable) begin
        mds_out_valid = 1'b0;
        if (pending) begin
          if (cnt == 0) begin
            mds_out_valid = 1'b1;
            mds_out = res;
            pending = 0;
          end else cnt--;
        end
        if (mds_valid && !unit_silent) begin
          pending = 1;
          cnt = unit_lat;
          res = unit_compute(mds_op, mds_a, mds_b);
        end
      end else begin
        pending = 0;
        mds_out_valid = inject_valid;
        mds_out = inject_data;
      end
    end
  end

  task automatic run_op(input vec_t v);
    int          n, pulses, bad, waited, hold_bad;
    logic [31:0] d0;
    logic [4:0]  r0;
    logic        e0;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin @(posedge clock); #1; waited++; end
    check({v.name, ":ready"}, 32'(req_ready), 32'd1);
    unit_lat = v.lat; unit_silent = v.silent; wb_ready = 1'b0;
    req_valid = 1'b1; req_instr = v.instr; req_rs1 = v.rs1; req_rs2 = v.rs2; req_rd = v.rd;
    @(posedge clock); #1;
    req_valid = 1'b0; req_instr = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
    req_rd = 5'($urandom);
    n = 0; pulses = 0; bad = 0;
    while (wb_valid !== 1'b1 && n < 200) begin
      if (mds_valid) pulses++;
      if (mds_valid && n != 0) bad++;
      if (v.unit && (mds_a !== v.rs1 || mds_b !== v.b || mds_op !== v.op)) bad++;
      if (req_ready !== 1'b0) bad++;
      @(posedge clock); #1; n++;
    end
    check({v.name, ":latency"}, 32'(n), 32'(v.n));
    check({v.name, ":wb_rd"}, 32'(wb_rd), 32'(v.rd));
    check({v.name, ":wb_data"}, wb_data, v.data);
    check({v.name, ":wb_err"}, 32'(wb_err), 32'(v.err));
    check({v.name, ":ready_in_wb"}, 32'(req_ready), 32'd0);
    check({v.name, ":issue_pulses"}, 32'(pulses), v.unit ? 32'd1 : 32'd0);
    check({v.name, ":issue_bus"}, 32'(bad), 32'd0);
    d0 = wb_data; r0 = wb_rd; e0 = wb_err; hold_bad = 0;
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clock); #1;
      if (wb_valid !== 1'b1 || wb_data !== d0 || wb_rd !== r0 || wb_err !== e0 ||
          req_ready !== 1'b0 || mds_valid !== 1'b0) hold_bad++;
    end
    if (v.bp > 0) check({v.name, ":backpressure_hold"}, 32'(hold_bad), 32'd0);
    wb_ready = 1'b1;
    @(posedge clock); #1;
    wb_ready = 1'b0;
    check({v.name, ":idle_after_wb"}, {30'd0, wb_valid, req_ready}, 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    vec_t        rv;
    logic [31:0] r;
    int          bad;

    vecs[0]  = mk("mul",      enc(7'h01, 3'd0, 7'h33, 5'd0), 32'd7, 32'd6, 5'd5, 0, 0, 0,
                  1, 4'd3, 32'd6, 32'd42, 0, 2);
    vecs[1]  = mk("srai",     enc(7'h20, 3'd5, 7'h13, 5'd4), 32'h8000_0000, 32'h1234_5678, 5'd9,
                  3, 0, 0, 1, 4'd2, 32'd4, 32'hF800_0000, 0, 5);
    vecs[2]  = mk("div0",     enc(7'h01, 3'd4, 7'h33, 5'd0), 32'd100, 32'd0, 5'd3, 0, 0, 0,
                  0, 4'd0, 32'd0, 32'hFFFF_FFFF, 0, 0);
    vecs[3]  = mk("rem0",     enc(7'h01, 3'd6, 7'h33, 5'd0), 32'd100, 32'd0, 5'd4, 0, 0, 0,
                  0, 4'd0, 32'd0, 32'd100, 0, 0);
    vecs[4]  = mk("divu",     enc(7'h01, 3'd5, 7'h33, 5'd0), 32'd100, 32'd7, 5'd6, 0, 0, 0,
                  0, 4'd0, 32'd0, 32'd0, 1, 0);
    vecs[5]  = mk("timeout",  enc(7'h01, 3'd0, 7'h33, 5'd0), 32'd3, 32'd4, 5'd7, 0, 1, 0,
                  1, 4'd3, 32'd4, 32'd0, 1, TO + 1);
    vecs[6]  = mk("sll_bp",   enc(7'h00, 3'd1, 7'h33, 5'd0), 32'd1, 32'd31, 5'd0, 1, 0, 5,
                  1, 4'd0, 32'd31, 32'h8000_0000, 0, 3);
    vecs[7]  = mk("div",      enc(7'h01, 3'd4, 7'h33, 5'd0), 32'd100, 32'd7, 5'd8, 2, 0, 0,
                  1, 4'd7, 32'd7, 32'd14, 0, 4);
    vecs[8]  = mk("add",      enc(7'h00, 3'd0, 7'h33, 5'd0), 32'd1, 32'd2, 5'd10, 0, 0, 1,
                  0, 4'd0, 32'd0, 32'd0, 1, 0);
    vecs[9]  = mk("slli",     enc(7'h00, 3'd1, 7'h13, 5'd3), 32'd5, 32'hFFFF_FFFF, 5'd12, 0, 0, 1,
                  1, 4'd0, 32'd3, 32'd40, 0, 2);
    vecs[10] = mk("mulhsu",   enc(7'h01, 3'd2, 7'h33, 5'd0), 32'd9, 32'd9, 5'd13, 0, 0, 0,
                  0, 4'd0, 32'd0, 32'd0, 1, 0);
    vecs[11] = mk("remu",     enc(7'h01, 3'd7, 7'h33, 5'd0), 32'd9, 32'd4, 5'd14, 0, 0, 0,
                  0, 4'd0, 32'd0, 32'd0, 1, 0);

    reset = 1'b1; req_valid = 1'b0; req_instr = 32'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    req_rd = 5'd0; wb_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset:req_ready", 32'(req_ready), 32'd0);
    check("reset:valids", {30'd0, mds_valid, wb_valid}, 32'd0);
    check("reset:wb", {26'd0, wb_err, wb_rd}, 32'd0);
    check("reset:wb_data", wb_data, 32'd0);
    check("reset:mds_bus", mds_a | mds_b | {28'd0, mds_op}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("reset:ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // reset while the unit is still working, then a stale completion pulse
    unit_silent = 1;
    req_valid = 1'b1; req_instr = enc(7'h01, 3'd0, 7'h33, 5'd0);
    req_rs1 = 32'd7; req_rs2 = 32'd6; req_rd = 5'd11;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    check("rst_wait:in_flight", {27'd0, wb_valid, mds_op}, 32'd3);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_wait:req_ready", 32'(req_ready), 32'd0);
    check("rst_wait:valids", {30'd0, mds_valid, wb_valid}, 32'd0);
    check("rst_wait:wb", {26'd0, wb_err, wb_rd}, 32'd0);
    check("rst_wait:wb_data", wb_data, 32'd0);
    check("rst_wait:mds_bus", mds_a | mds_b | {28'd0, mds_op}, 32'd0);
    reset = 1'b0; unit_enable = 0; inject_valid = 1'b1; inject_data = 32'hDEAD_BEEF;
    bad = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (wb_valid !== 1'b0 || mds_valid !== 1'b0 || req_ready !== 1'b1 || wb_data !== 32'd0) bad++;
    end
    check("rst_wait:late_valid_ignored", 32'(bad), 32'd0);
    inject_valid = 1'b0; unit_enable = 1; unit_silent = 0;
    @(posedge clock); #1;

    for (int i = 0; i < 60; i++) begin
      logic [6:0] opc, f7;
      logic [2:0] f3;
      r = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    opc = 7'h33;
        2:       opc = 7'h13;
        default: opc = r[6:0];
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = r[13:7];
      endcase
      f3 = r[16:14];
      if (opc == 7'h13 && f3 == 3'd1) f7 = 7'h00;
      rv.name = $sformatf("rand%0d", i);
      rv.instr = enc(f7, f3, opc, r[21:17]);
      rv.rs1 = $urandom;
      rv.rs2 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rv.rd = r[26:22];
      rv.lat = int'($urandom_range(0, 4));
      rv.silent = 0;
      rv.bp = int'($urandom_range(0, 2));
      ref_model(rv.instr, rv.rs1, rv.rs2, rv.unit, rv.op, rv.b, rv.data, rv.err);
      rv.n = rv.unit ? rv.lat + 2 : 0;
      run_op(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
